// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver state encoding and baud divider helper
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    longint d;
    d = (longint'(clk_freq) + longint'(baud) * longint'(os) / longint'(2)) / (longint'(baud) * longint'(os));
    return (d < longint'(1)) ? 1 : int'(d);
  endfunction
endpackage

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial line in, received symbol strobe and status out
interface uart_rx_cfg_if #(parameter int MSG_BITS = 8);
  logic uart_i;
  logic [MSG_BITS-1:0] symbol_o;
  logic newSymbol_o;
  logic parityErr_o;
  logic frameErr_o;
  logic busy_o;
  modport master(output uart_i, input symbol_o, newSymbol_o, parityErr_o, frameErr_o, busy_o);
  modport slave(input uart_i, output symbol_o, newSymbol_o, parityErr_o, frameErr_o, busy_o);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: one-cycle tick every DIV clocks, phase restartable
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q;
  logic wrap;
  assign wrap = cnt_q == W'(DIV - 1);
  assign tick_o = wrap & ~restart_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= (restart_i || wrap) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with parity/framing checks.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote around mid-bit.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int MSG_BITS    = 8,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input logic clk,
  input logic rst,
  uart_rx_cfg_if.slave bus
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(MSG_BITS);
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMP = OVERSAMPLE / 2;
`else
  localparam int SAMP = OVERSAMPLE / 2 - 1;
`endif
  logic s1_q, s2_q, line_q, fall, tick, restart, samp, bit_v;
  logic [1:0] fill_q;
  logic [TW-1:0] tcnt_q;
  state_t state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [MSG_BITS-1:0] shift_q, shift_d, sym_q, sym_d;
  logic perr_q, perr_d, ferr_q, ferr_d, new_q, new_d, pe_q, pe_d, fe_q, fe_d, busy_q, busy_d;

  // line_q only follows the pin once the synchroniser holds real data, so a
  // line still low at reset release never looks like a start edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      line_q <= 1'b0;
      fill_q <= '0;
    end else begin
      s1_q   <= bus.uart_i;
      s2_q   <= s1_q;
      fill_q <= {fill_q[0], 1'b1};
      line_q <= fill_q[1] & s2_q;
    end
  assign fall = line_q & ~s2_q;

  uart_baud_gen #(.DIV(DIV)) u_baud (.clk(clk), .rst(rst), .restart_i(restart), .tick_o(tick));

  always_ff @(posedge clk or posedge rst)
    if (rst) tcnt_q <= '0;
    else if (restart) tcnt_q <= '0;
    else if (tick) tcnt_q <= (tcnt_q == TW'(OVERSAMPLE - 1)) ? '0 : tcnt_q + 1'b1;
  assign samp = tick && tcnt_q == TW'(SAMP);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) vote_q <= 2'b11;
    else if (tick) vote_q <= {vote_q[0], s2_q};
  assign bit_v = (vote_q[1] & vote_q[0]) | (vote_q[1] & s2_q) | (vote_q[0] & s2_q);
`else
  assign bit_v = s2_q;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      sym_q   <= '0;
      new_q   <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      sym_q   <= sym_d;
      new_q   <= new_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
    end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    sym_d   = sym_q;
    new_d   = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    busy_d  = busy_q;
    restart = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        restart = 1'b1;
        busy_d  = 1'b1;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        bcnt_d  = '0;
      end
      START: if (samp) begin
        state_d = bit_v ? IDLE : DATA;
        busy_d  = ~bit_v;
      end
      DATA: if (samp) begin
        shift_d = {bit_v, shift_q[MSG_BITS-1:1]};
        bcnt_d  = bcnt_q + 1'b1;
        if (bcnt_q == BW'(MSG_BITS - 1)) begin
          bcnt_d  = '0;
          state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
        end
      end
      PARITY: if (samp) begin
        perr_d  = bit_v ^ (^shift_q) ^ (PARITY_MODE == PARITY_ODD);
        state_d = STOP;
      end
      STOP: if (samp) begin
        ferr_d = ferr_q | ~bit_v;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BW'(STOP_BITS - 1)) begin
          state_d = bit_v ? IDLE : WAIT_HIGH;
          busy_d  = ~bit_v;
          new_d   = 1'b1;
          sym_d   = shift_q;
          pe_d    = perr_q;
          fe_d    = ferr_q | ~bit_v;
        end
      end
      WAIT_HIGH: if (s2_q) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.symbol_o    = sym_q;
  assign bus.newSymbol_o = new_q;
  assign bus.parityErr_o = pe_q;
  assign bus.frameErr_o  = fe_q;
  assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: four receiver configurations checked against a frame-level model
module tb_uart_rx_cfg;
  localparam int DIV = 10;
  localparam int OS  = 16;
  localparam int BIT = DIV * OS;
  localparam int MB[4] = '{8, 8, 8, 9};
  localparam int PM[4] = '{0, 1, 2, 0};
  localparam int SB[4] = '{1, 1, 1, 2};
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  typedef struct {
    int k;
    logic [8:0] sym;
    logic pe;
    logic fe;
    int t0;
    int nom;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ln[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.MSG_BITS(8)) b0();
  uart_rx_cfg_if #(.MSG_BITS(8)) b1();
  uart_rx_cfg_if #(.MSG_BITS(8)) b2();
  uart_rx_cfg_if #(.MSG_BITS(9)) b3();

  uart_rx_cfg #(.CLK_FREQ(18_432_000), .BAUD_RATE(115200), .MSG_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(16))
    d0 (.clk(clk), .rst(rst), .bus(b0.slave));
  uart_rx_cfg #(.CLK_FREQ(18_432_000), .BAUD_RATE(115200), .MSG_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16))
    d1 (.clk(clk), .rst(rst), .bus(b1.slave));
  uart_rx_cfg #(.CLK_FREQ(18_432_000), .BAUD_RATE(115200), .MSG_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .OVERSAMPLE(16))
    d2 (.clk(clk), .rst(rst), .bus(b2.slave));
  uart_rx_cfg #(.CLK_FREQ(18_432_000), .BAUD_RATE(115200), .MSG_BITS(9), .PARITY_MODE(0), .STOP_BITS(2), .OVERSAMPLE(16))
    d3 (.clk(clk), .rst(rst), .bus(b3.slave));

  assign b0.uart_i = ln[0];
  assign b1.uart_i = ln[1];
  assign b2.uart_i = ln[2];
  assign b3.uart_i = ln[3];

  logic [8:0] sym[4];
  logic nw[4], pe[4], fe[4], bz[4];
  assign sym[0] = {1'b0, b0.symbol_o};
  assign sym[1] = {1'b0, b1.symbol_o};
  assign sym[2] = {1'b0, b2.symbol_o};
  assign sym[3] = b3.symbol_o;
  assign nw[0] = b0.newSymbol_o;
  assign nw[1] = b1.newSymbol_o;
  assign nw[2] = b2.newSymbol_o;
  assign nw[3] = b3.newSymbol_o;
  assign pe[0] = b0.parityErr_o;
  assign pe[1] = b1.parityErr_o;
  assign pe[2] = b2.parityErr_o;
  assign pe[3] = b3.parityErr_o;
  assign fe[0] = b0.frameErr_o;
  assign fe[1] = b1.frameErr_o;
  assign fe[2] = b2.frameErr_o;
  assign fe[3] = b3.frameErr_o;
  assign bz[0] = b0.busy_o;
  assign bz[1] = b1.busy_o;
  assign bz[2] = b2.busy_o;
  assign bz[3] = b3.busy_o;

  task automatic chk(input string n, input int act, input int req, input int tol = 0);
    vectors++;
    if (act > req + tol || act < req - tol) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (tolerance %0d) at cycle %0d", n, act, req, tol, cyc);
    end
  endtask

  // Frame-level expectation: the latency is the mid-point of the last stop bit
  // measured in baud ticks, plus synchroniser/edge/output register delay.
  function automatic exp_t model(input int k, input logic [8:0] d, input logic par, input logic [1:0] st, input int t0);
    exp_t e;
    logic [8:0] m;
    m = d & 9'((1 << MB[k]) - 1);
    e.k = k;
    e.sym = m;
    e.pe = (PM[k] != 0) && (par != ((^m) ^ (PM[k] == 2)));
    e.fe = (st[0] == 1'b0) || (SB[k] == 2 && st[1] == 1'b0);
    e.t0 = t0;
    e.nom = DIV * (OS * (MB[k] + ((PM[k] != 0) ? 1 : 0) + SB[k]) + OS / 2 + MAJ) + 4;
    return e;
  endfunction

  task automatic send(input int k, input logic [8:0] d, input logic par, input logic [1:0] st, input bit spike,
                      input bit lit, input logic [8:0] lsym, input logic lpe, input logic lfe);
    logic lv[$];
    exp_t e;
    @(posedge clk);
    #1;
    lv.push_back(1'b0);
    for (int i = 0; i < MB[k]; i++) lv.push_back(d[i]);
    if (PM[k] != 0) lv.push_back(par);
    for (int i = 0; i < SB[k]; i++) lv.push_back(st[i]);
    e = model(k, d, par, st, cyc);
    if (lit) begin
      e.sym = lsym;
      e.pe = lpe;
      e.fe = lfe;
    end
    q.push_back(e);
    foreach (lv[i]) begin
      ln[k] = lv[i];
      if (spike && i == 1) begin
        repeat (BIT / 2) @(posedge clk);
        #1 ln[k] = ~lv[i];
        @(posedge clk);
        #1 ln[k] = lv[i];
        repeat (BIT / 2 - 1) @(posedge clk);
      end else begin
        repeat (BIT) @(posedge clk);
      end
      #1;
    end
    ln[k] = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        chk($sformatf("reset_outputs_dut%0d", k), int'({sym[k], nw[k], pe[k], fe[k], bz[k]}), 0);
      end else if (nw[k]) begin
        if (q.size() == 0) begin
          chk($sformatf("unexpected_strobe_dut%0d", k), int'(nw[k]), 0);
        end else begin
          e = q.pop_front();
          chk("strobe_dut", k, e.k);
          chk($sformatf("symbol_dut%0d", k), int'(sym[k]), int'(e.sym));
          chk($sformatf("parityErr_dut%0d", k), int'(pe[k]), int'(e.pe));
          chk($sformatf("frameErr_dut%0d", k), int'(fe[k]), int'(e.fe));
          chk($sformatf("latency_dut%0d", k), cyc - e.t0, e.nom, 4);
        end
      end else begin
        chk($sformatf("flags_without_strobe_dut%0d", k), int'({pe[k], fe[k]}), 0);
      end
    end
    if (!rst && q.size() > 0 && cyc > q[0].t0 + q[0].nom + 4) begin
      chk($sformatf("missing_strobe_dut%0d", q[0].k), int'(nw[q[0].k]), 1);
      void'(q.pop_front());
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted with %0d expected strobes pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);

    // 8N1 basic frame
    send(0, 9'h0A5, 1'b0, 2'b11, 0, 1, 9'h0A5, 1'b0, 1'b0);
    // even parity: 0x07 has odd weight, so parity bit 0 is wrong and 1 is right
    send(1, 9'h007, 1'b0, 2'b11, 0, 1, 9'h007, 1'b1, 1'b0);
    send(1, 9'h007, 1'b1, 2'b11, 0, 1, 9'h007, 1'b0, 1'b0);
    send(2, 9'h007, 1'b0, 2'b11, 0, 1, 9'h007, 1'b0, 1'b0);
    send(2, 9'h007, 1'b1, 2'b11, 0, 1, 9'h007, 1'b1, 1'b0);

    // false start
    @(posedge clk);
    #1 ln[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1 ln[0] = 1'b1;
    chk("glitch_busy_high", int'(bz[0]), 1);
    for (int i = 0; i < BIT && bz[0]; i++) @(posedge clk);
    #1 chk("glitch_busy_cleared", int'(bz[0]), 0);
    send(0, 9'h03C, 1'b0, 2'b11, 0, 1, 9'h03C, 1'b0, 1'b0);

    // break: one error frame only
    @(posedge clk);
    #1 ln[0] = 1'b0;
    e = '{k: 0, sym: 9'h000, pe: 1'b0, fe: 1'b1, t0: cyc, nom: DIV * (OS * 9 + OS / 2 + MAJ) + 4};
    q.push_back(e);
    repeat (20 * BIT) @(posedge clk);
    #1 chk("break_busy_held", int'(bz[0]), 1);
    ln[0] = 1'b1;
    repeat (BIT) @(posedge clk);
    #1 chk("break_busy_cleared", int'(bz[0]), 0);
    send(0, 9'h03C, 1'b0, 2'b11, 0, 1, 9'h03C, 1'b0, 1'b0);

    // reset mid-DATA of 0x5A, line held low across release
    @(posedge clk);
    #1 ln[0] = 1'b0;
    repeat (BIT) @(posedge clk);
    #1 ln[0] = 1'b0;
    repeat (BIT) @(posedge clk);
    #1 ln[0] = 1'b1;
    repeat (BIT) @(posedge clk);
    #1 ln[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1 chk("cut_frame_busy", int'(bz[0]), 1);
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    repeat (200) @(posedge clk);
    #1 chk("post_reset_low_ignored", int'(bz[0]), 0);
    ln[0] = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    send(0, 9'h05A, 1'b0, 2'b11, 0, 1, 9'h05A, 1'b0, 1'b0);

    // 9-bit, two stop bits
    send(3, 9'h1FF, 1'b0, 2'b11, 0, 1, 9'h1FF, 1'b0, 1'b0);
    send(3, 9'h001, 1'b0, 2'b11, 0, 1, 9'h001, 1'b0, 1'b0);
    send(3, 9'h0AA, 1'b0, 2'b01, 0, 1, 9'h0AA, 1'b0, 1'b1);
    repeat (BIT) @(posedge clk);

`ifdef UART_RX_MAJORITY_EN
    send(0, 9'h000, 1'b0, 2'b11, 1, 1, 9'h000, 1'b0, 1'b0);
`endif

    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 5; n++) begin
        logic [8:0] d;
        logic par;
        logic [1:0] st;
        int gap;
        d = 9'($urandom_range(0, 511));
        par = 1'($urandom_range(0, 1));
        st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        send(k, d, par, st, 0, 0, 9'h000, 1'b0, 1'b0);
        gap = $urandom_range(0, BIT);
        if (!st[SB[k] - 1]) gap += 20;
        repeat (gap) @(posedge clk);
      end
    end

    for (int i = 0; i < 3000 && q.size() > 0; i++) @(negedge clk);
    chk("expectations_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the basic fixed-format receiver. Adds configurable data width, parity (none/even/odd), 1 or 2 stop bits, oversampling, false-start rejection, and parity/framing error reporting. Sits between the asynchronous serial pin and the message-parsing logic; delivers one symbol per received frame as a single-cycle strobe.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s
MSG_BITS, 8, data bits per frame; legal range 5..9
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 16, sample ticks per bit; even, at least 8

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
uart_i  in  1  asynchronous serial line, idle high
symbol_o  out  MSG_BITS  last received data word, LSB = first bit on the line
newSymbol_o  out  1  one-cycle strobe; symbol_o and error flags are valid with it
parityErr_o  out  1  parity mismatch on this frame; valid only with newSymbol_o
frameErr_o  out  1  a stop bit was sampled low; valid only with newSymbol_o
busy_o  out  1  high from start-edge detection until return to IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0. Synchroniser flops reset to 1 (idle line). FSM resets to IDLE.
- Input path: 2-flop synchroniser, then a falling-edge detector on the synchronised line.
- Tick generator: DIV = round(CLK_FREQ / (BAUD_RATE*OVERSAMPLE)), minimum 1. Emits a one-cycle tick every DIV clocks. The tick counter restarts on start-edge detection so sampling phase is aligned to the edge.
- Per-bit sampling: tick counter 0..OVERSAMPLE-1; the bit value is taken at tick OVERSAMPLE/2 (mid-bit).
- FSM states and transitions:
  - IDLE -> START on a falling edge.
  - START: mid-bit sample high = false start, go to IDLE with no output. Sample low -> DATA.
  - DATA: shift in MSG_BITS bits, LSB first. Go to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: compute expected = XOR of data bits (even mode) or its inverse (odd mode); latch mismatch.
  - STOP: sample STOP_BITS stop bits; any low sample sets the frame error.
  - STOP -> IDLE after the final stop-bit mid sample, or -> WAIT_HIGH if that sample was low.
  - WAIT_HIGH -> IDLE once the synchronised line is high (break handling: one error frame only).
- Output timing: newSymbol_o pulses in the clk cycle after the last stop bit's mid-sample. symbol_o updates in that same cycle and holds until the next strobe. parityErr_o/frameErr_o are 0 whenever newSymbol_o is 0.
- Frames with errors still deliver symbol_o, with the relevant flag(s) set.
- The falling edge of a following start bit is accepted from IDLE immediately. The second half of the stop bit is not waited for, which tolerates +/-~4% baud mismatch.
- Reset mid-frame: all state is abandoned at once. A line that is low after reset release is ignored until it has been seen high (use WAIT_HIGH as the post-reset state if the line is low).
- Counter widths: clog2 of each counter's range. No overflow is possible within legal parameter ranges.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: every bit value, including start, parity and stop, is the 2-of-3 majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. Output timing shifts one tick later.
- Undefined: the single mid-bit sample is used.

Decomposition:
- Package uart_pkg: PARITY_NONE/EVEN/ODD constants, FSM state encoding, function computing DIV with rounding and minimum clamp.
- Sub-module uart_baud_gen: tick divider with synchronous restart input, reusable by the future transmitter.

Test Plan (CLK_FREQ=18_432_000, BAUD_RATE=115200, OVERSAMPLE=16 -> DIV=10, 160 clk/bit):
1. 8N1, send 0xA5 -> exactly one newSymbol_o pulse, symbol_o=0xA5, both error flags 0. Pulse within 1520+/-4 clk of the start edge (plus synchroniser delay).
2. 8E1, send 0x07 with parity bit driven 0 -> symbol_o=0x07, parityErr_o=1, frameErr_o=0. Repeat with parity bit 1 -> parityErr_o=0. Odd mode with the same frames -> results inverted.
3. Low glitch of 40 clk on an idle line -> no newSymbol_o; busy_o returns to 0 within 1 bit time; a following 0x3C frame is received correctly.
4. Line held low for 20 bit times, then high -> one pulse with symbol_o=0x00 and frameErr_o=1, no further pulses. Next frame 0x3C is received cleanly.
5. rst asserted mid-DATA of frame 0x5A, released, then 0x5A resent -> outputs 0 during reset, no pulse for the cut frame, one clean pulse with 0x5A.
6. MSG_BITS=9, STOP_BITS=2, back-to-back frames 0x1FF and 0x001 -> two pulses in order, no errors. A second stop bit driven low -> frameErr_o=1. With UART_RX_MAJORITY_EN, a 1-clk high spike at mid-bit of data bit 0 of 0x00 is rejected (symbol_o=0x00).
